// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - round-robin arbiter sharing one booth_8x8 multiplier among NREQ requesters
// Optional timeout watchdog enabled by defining BOOTH_ARB_TIMEOUT_EN.
module booth_mul_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [15:0]       result,
    output logic              err,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    output logic              mul_start,
    input  logic [15:0]       mul_ab,
    input  logic              mul_busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_START     = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_RESP      = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [15:0]     result_q, result_d;
    logic [7:0]      mul_a_q, mul_a_d;
    logic [7:0]      mul_b_q, mul_b_d;

    logic            pick_found;
    logic [PW-1:0]   pick_idx;
    int              idx;

`ifdef BOOTH_ARB_TIMEOUT_EN
    logic [5:0]      tmo_cnt_q, tmo_cnt_d;
    logic            tmo_q, tmo_d;
`endif

    // First asserted request at or after rr_q, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gidx_d   = gidx_q;
        gnt_d    = gnt_q;
        result_d = result_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    gidx_d  = pick_idx;
                    gnt_d   = NREQ'(1) << pick_idx;
                    mul_a_d = req_a[8*pick_idx +: 8];
                    mul_b_d = req_b[8*pick_idx +: 8];
                    state_d = S_START;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
                    tmo_d     = 1'b0;
`endif
                end
            end
            S_START: begin
                if (mul_busy) begin
                    state_d = S_WAIT_DONE;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == 6'd7) begin
                    result_d = '0;
                    tmo_d    = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 6'd1;
`endif
                end
            end
            S_WAIT_DONE: begin
                if (!mul_busy) begin
                    result_d = mul_ab;
                    state_d  = S_RESP;
`ifdef BOOTH_ARB_TIMEOUT_EN
                end else if (tmo_cnt_q == 6'd63) begin
                    result_d = '0;
                    tmo_d    = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 6'd1;
`endif
                end
            end
            default: begin
                gnt_d   = '0;
                rr_d    = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            gidx_q   <= '0;
            gnt_q    <= '0;
            result_q <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gidx_q   <= gidx_d;
            gnt_q    <= gnt_d;
            result_q <= result_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
        end
    end

`ifdef BOOTH_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign err = (state_q == S_RESP) && tmo_q;
`else
    assign err = 1'b0;
`endif

    // done and mul_start decode straight from state so reset clears them at once.
    assign done      = (state_q == S_RESP) ? gnt_q : '0;
    assign mul_start = (state_q == S_START);
    assign gnt       = gnt_q;
    assign result    = result_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb/tb_booth_mul_arbiter.sv - scoreboard bench for booth_mul_arbiter with a behavioural multiplier
module tb_booth_mul_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [15:0]       result;
    logic              err;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic              mul_start;
    logic [15:0]       mul_ab;
    logic              mul_busy;

    logic              stuck;
    int                mcnt;

    typedef struct {
        logic [3:0]  d;
        logic [15:0] r;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   ndone      = 0;

    booth_mul_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .done      (done),
        .result    (result),
        .err       (err),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_start (mul_start),
        .mul_ab    (mul_ab),
        .mul_busy  (mul_busy)
    );

    always #5 clk = ~clk;

    // Multiplier model: busy for LAT cycles after an accepted start, signed product.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_busy <= 1'b0;
            mcnt     <= 0;
            mul_ab   <= '0;
        end else if (mul_busy) begin
            if (mcnt == 0) mul_busy <= 1'b0;
            else           mcnt <= mcnt - 1;
        end else if (mul_start && !stuck) begin
            mul_busy <= 1'b1;
            mcnt     <= LAT - 1;
            mul_ab   <= 16'($signed(mul_a) * $signed(mul_b));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
        if (done !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_idx", 32'(done), 32'(e.d));
                check("result", 32'(result), 32'(e.r));
                check("err", 32'(err), 32'(e.e));
            end
            ndone++;
        end else begin
            check("err_without_done", 32'(err), 32'd0);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [15:0] r, input logic e);
        exp_t x;
        x.d = 4'(1 << i);
        x.r = r;
        x.e = e;
        sb.push_back(x);
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    task automatic wait_dones(input int target, input bit drop_on_gnt);
        int n = 0;
        while (ndone < target && n < 300) begin
            step();
            if (drop_on_gnt) req = req & ~gnt;
            n++;
        end
        check("done_timeout", 32'(ndone >= target), 32'd1);
    endtask

    task automatic wait_gnt();
        int n = 0;
        while (gnt == '0 && n < 50) begin
            step();
            n++;
        end
        check("gnt_timeout", 32'(gnt != '0), 32'd1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int n;
        int starts;
        rst_n = 1'b0;
        req   = '0;
        req_a = '0;
        req_b = '0;
        stuck = 1'b0;
        step();
        step();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_mul_start", 32'(mul_start), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        step();

        // Single requester 0: 3*17, req dropped mid-operation
        set_ops(0, 8'd3, 8'd17);
        push(0, 16'd51, 1'b0);
        req = 4'b0001;
        wait_gnt();
        check("t1_gnt", 32'(gnt), 32'b0001);
        check("t1_mul_start", 32'(mul_start), 32'd1);
        check("t1_mul_a", 32'(mul_a), 32'd3);
        req = '0;
        wait_dones(1, 1'b0);

        // Two simultaneous requests, rr_ptr back at 0
        pulse_reset();
        set_ops(0, 8'd7, 8'd7);
        set_ops(1, 8'd3, 8'd17);
        push(0, 16'd49, 1'b0);
        push(1, 16'd51, 1'b0);
        req = 4'b0011;
        wait_dones(3, 1'b1);

        // All four held high: 0,1,2,3,0
        pulse_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i + 1), 8'(10 + i));
        push(0, 16'd10, 1'b0);
        push(1, 16'd22, 1'b0);
        push(2, 16'd36, 1'b0);
        push(3, 16'd52, 1'b0);
        push(0, 16'd10, 1'b0);
        req = 4'b1111;
        wait_dones(8, 1'b0);
        req = '0;
        step();
        step();

        // Signed operands; operand change after grant ignored
        set_ops(2, 8'hFF, 8'h02);
        push(2, 16'hFFFE, 1'b0);
        req = 4'b0100;
        wait_gnt();
        set_ops(2, 8'h05, 8'h05);
        req = '0;
        wait_dones(9, 1'b0);
        step();

        // Reset during WAIT_DONE abandons the operation
        set_ops(3, 8'd5, 8'd6);
        req = 4'b1000;
        n = 0;
        while (!(gnt != '0 && mul_busy && !mul_start) && n < 50) begin
            step();
            n++;
        end
        check("t5_reach_wait", 32'(n < 50), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_gnt", 32'(gnt), 32'd0);
        check("t5_result", 32'(result), 32'd0);
        check("t5_mul_ab_ops", 32'({mul_a, mul_b}), 32'd0);
        check("t5_mul_start", 32'(mul_start), 32'd0);
        req = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("t5_no_done", 32'(ndone), 32'd9);
        set_ops(3, 8'd2, 8'hFD);
        push(3, 16'hFFFA, 1'b0);
        req = 4'b1000;
        wait_dones(10, 1'b1);
        step();

`ifdef BOOTH_ARB_TIMEOUT_EN
        // Multiplier never goes busy: 8 START cycles then err with done
        stuck  = 1'b1;
        set_ops(0, 8'd1, 8'd1);
        push(0, 16'd0, 1'b1);
        req    = 4'b0001;
        starts = 0;
        n      = 0;
        while (ndone < 11 && n < 100) begin
            step();
            req = req & ~gnt;
            if (mul_start) starts++;
            n++;
        end
        check("tmo_done", 32'(ndone), 32'd11);
        check("tmo_start_cycles", 32'(starts), 32'd8);
        stuck = 1'b0;
`endif

        step();
        step();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/booth_mul_arbiter.md
BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing one booth_8x8 multiplier (2..8).
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  NREQ  per-requester request level.
REQ-005 Port: req_a  input  8*NREQ  flattened multiplicand, requester i at bits [8i+7:8i].
REQ-006 Port: req_b  input  8*NREQ  flattened multiplier, same packing as req_a.
REQ-007 Port: gnt  output  NREQ  one-hot grant, held for the whole operation.
REQ-008 Port: done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-009 Port: result  output  16  product of the last completed operation, held until the next one completes.
REQ-010 Port: err  output  1  one-cycle pulse coincident with done on a timed-out operation.
REQ-011 Port: mul_a, mul_b  output  8 each  operands driven to the multiplier.
REQ-012 Port: mul_start  output  1  multiplier start.
REQ-013 Port: mul_ab  input  16  multiplier product.
REQ-014 Port: mul_busy  input  1  multiplier busy; mul_ab valid on the first cycle mul_busy is low after being high.

Function
REQ-015 FSM states: IDLE, START, WAIT_DONE, RESP; one state per cycle minimum.
REQ-016 IDLE: if any req bit is high, grant the first high bit at or after rr_ptr (wrapping modulo NREQ), latch its operands into mul_a/mul_b, set gnt, go to START.
REQ-017 START: mul_start=1 every cycle; on the first cycle mul_busy=1, drop mul_start and go to WAIT_DONE.
REQ-018 WAIT_DONE: on the first cycle mul_busy=0, register mul_ab into result and go to RESP.
REQ-019 RESP: done[g]=1 for exactly one cycle, gnt cleared, rr_ptr=(g+1) mod NREQ, go to IDLE.
REQ-020 Operands are sampled only at grant; req_a/req_b may change after grant without effect.
REQ-021 A requester dropping req during its operation does not abort it; done still pulses.
REQ-022 req still high after done counts as a new request and competes from the advanced rr_ptr.
REQ-023 Simultaneous requests: round-robin order strictly; no requester waits more than NREQ-1 operations.
REQ-024 At most one of gnt and at most one of done is high in any cycle; mul_start is never high outside START.
REQ-025 result is passed through unmodified (16-bit signed product from the multiplier).

Reset
REQ-026 rst_n low asynchronously forces IDLE, rr_ptr=0, gnt=0, done=0, err=0, mul_start=0, mul_a=0, mul_b=0, result=0.
REQ-027 Reset mid-operation abandons the operation with no done pulse; first grant after release is evaluated in IDLE.

Configuration
REQ-028 Macro BOOTH_ARB_TIMEOUT_EN defined: START times out after 8 cycles without mul_busy=1, WAIT_DONE after 64 cycles with mul_busy=1; on timeout go to RESP with result=0 and err=1 with done.
REQ-029 Macro BOOTH_ARB_TIMEOUT_EN undefined: START and WAIT_DONE wait indefinitely; err tied to 0; no timeout counter.

Verification
REQ-030 Single requester 0, a=3 b=17 -> gnt=0001, mul_start until busy, done[0] pulse, result=51.
REQ-031 Requesters 0 (7*7) and 1 (3*17) raised same cycle -> requester 0 served first (result=49), then requester 1 (result=51); never both gnt bits high.
REQ-032 All four req held high continuously -> grant order 0,1,2,3,0; exactly one done per operation.
REQ-033 Requester 2, a=8'hFF b=8'h02 -> result=16'hFFFE; req_a changed after grant has no effect.
REQ-034 rst_n pulsed low during WAIT_DONE -> all outputs 0 immediately, no done, next request served normally.
REQ-035 With BOOTH_ARB_TIMEOUT_EN, mul_busy stuck low -> 8 cycles in START, then done and err pulse together, result=0.
